avmm_sdram_responder: RTL and testbench



---
 rtl/avmm_sdram_responder.sv | 140 ++++++++++++++
 tb/tb_avmm_sdram_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/avmm_sdram_responder.sv
// Avalon-MM slave scratch memory for the wordcopy master port: fixed-latency
// pipelined reads, byte-enabled writes, programmable stalls and read backpressure.
module avmm_sdram_responder #(
   parameter int unsigned DEPTH_LOG2   = 10,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MAX_PENDING  = 2,
   parameter int unsigned STALL_PERIOD = 0,
   parameter int unsigned STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        waitrequest,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        readdatavalid,
   output logic        err,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {S_RUN, S_STALL} stall_state_t;

   logic [31:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  out_of_range;
   logic                  unused_addr_bits;
   logic                  accept;
   logic                  rd_acc;
   logic                  wr_acc;
   logic [7:0]            inflight;

   logic [READ_LATENCY-1:0] pv;
   logic [READ_LATENCY-1:0] pv_in;
   logic [31:0]             pd    [READ_LATENCY];
   logic [31:0]             pd_in [READ_LATENCY];

   stall_state_t state, state_n;
   logic [31:0]  cmd_cnt, cmd_cnt_n;
   logic [31:0]  stall_cnt, stall_cnt_n;

   assign word_idx         = address[DEPTH_LOG2+1:2];
   assign out_of_range     = |address[31:DEPTH_LOG2+2];
   assign unused_addr_bits = ^address[1:0];

   // Registered state only (plus rst), so a master may gate read/write on it.
   assign waitrequest = rst | (state == S_STALL) | (inflight >= 8'(MAX_PENDING));
   assign accept      = (read | write) & ~waitrequest;
   assign wr_acc      = accept & write;
   assign rd_acc      = accept & read & ~write;

   always_ff @(posedge clk) begin
      if (wr_acc && !out_of_range) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (byteenable[b]) mem[word_idx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

   always_comb begin
      pv_in[0] = rd_acc;
      pd_in[0] = out_of_range ? 32'hDEAD_BEEF : mem[word_idx];
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         pv_in[i] = pv[i-1];
         pd_in[i] = pd[i-1];
      end
   end

   // Data stages load only alongside a valid bit, so readdata holds between strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pv <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
      end else begin
         pv <= pv_in;
         for (int unsigned i = 0; i < READ_LATENCY; i++) begin
            if (pv_in[i]) pd[i] <= pd_in[i];
         end
      end
   end

   assign readdatavalid = pv[READ_LATENCY-1];
   assign readdata      = pd[READ_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
         rd_count <= '0;
         wr_count <= '0;
         err      <= 1'b0;
      end else begin
         inflight <= inflight + 8'(rd_acc) - 8'(readdatavalid);
         if (rd_acc) rd_count <= rd_count + 32'd1;
         if (wr_acc) wr_count <= wr_count + 32'd1;
         if (accept && (out_of_range || (read && write))) err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         cmd_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         state     <= state_n;
         cmd_cnt   <= cmd_cnt_n;
         stall_cnt <= stall_cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      cmd_cnt_n   = cmd_cnt;
      stall_cnt_n = stall_cnt;
      case (state)
         S_RUN: begin
            if (accept && (STALL_PERIOD != 0)) begin
               if (cmd_cnt == 32'(STALL_PERIOD - 1)) begin
                  cmd_cnt_n   = '0;
                  stall_cnt_n = '0;
                  state_n     = S_STALL;
               end else begin
                  cmd_cnt_n = cmd_cnt + 32'd1;
               end
            end
         end
         S_STALL: begin
            if (stall_cnt >= 32'(STALL_CYCLES - 1)) state_n = S_RUN;
            else                                     stall_cnt_n = stall_cnt + 32'd1;
         end
         default: state_n = S_RUN;
      endcase
   end

endmodule

// File: tb/tb_avmm_sdram_responder.sv
// Directed bench: instance a (MAX_PENDING=1, no stalls) for data paths,
// instance b (STALL_PERIOD=2, STALL_CYCLES=3) for the stall generator.
module tb_avmm_sdram_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_wait, a_read, a_write, a_rdv, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata, a_rdcnt, a_wrcnt;
   logic [3:0]  a_be;

   logic        b_wait, b_read, b_write, b_rdv, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata, b_rdcnt, b_wrcnt;
   logic [3:0]  b_be;

   int checks = 0;
   int errors = 0;

   avmm_sdram_responder #(
      .DEPTH_LOG2(10), .READ_LATENCY(2), .MAX_PENDING(1), .STALL_PERIOD(0), .STALL_CYCLES(1)
   ) u_a (
      .clk(clk), .rst(rst), .waitrequest(a_wait), .address(a_addr), .read(a_read),
      .write(a_write), .byteenable(a_be), .writedata(a_wdata), .readdata(a_rdata),
      .readdatavalid(a_rdv), .err(a_err), .rd_count(a_rdcnt), .wr_count(a_wrcnt)
   );

   avmm_sdram_responder #(
      .DEPTH_LOG2(10), .READ_LATENCY(2), .MAX_PENDING(2), .STALL_PERIOD(2), .STALL_CYCLES(3)
   ) u_b (
      .clk(clk), .rst(rst), .waitrequest(b_wait), .address(b_addr), .read(b_read),
      .write(b_write), .byteenable(b_be), .writedata(b_wdata), .readdata(b_rdata),
      .readdatavalid(b_rdv), .err(b_err), .rd_count(b_rdcnt), .wr_count(b_wrcnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a command on instance a and return just after its accept edge.
   task automatic a_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
      int n;
      a_addr = addr; a_wdata = data; a_be = be; a_read = rd; a_write = wr;
      n = 0;
      while (a_wait && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("a_accept_timeout", 32'(n), 32'd0);
      tick();
      a_read = 1'b0; a_write = 1'b0;
   endtask

   task automatic a_read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      a_cmd(1'b1, 1'b0, addr, 32'h0, 4'h0);
      chk({tag, "_early"}, 32'(a_rdv), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(a_rdv), 32'd1);
      chk({tag, "_data"}, a_rdata, exp);
      tick();
      chk({tag, "_one_shot"}, 32'(a_rdv), 32'd0);
      chk({tag, "_hold"}, a_rdata, exp);
   endtask

   initial begin
      logic [31:0] got [4];
      logic [9:0]  hist;
      int          acc, got_n;
      logic        accepting;

      rst = 1'b1;
      a_read = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
      b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
      tick(); tick(); tick();
      chk("rst_wait", 32'(a_wait), 32'd1);
      chk("rst_rdv", 32'(a_rdv), 32'd0);
      chk("rst_rdata", a_rdata, 32'h0);
      chk("rst_err", 32'(a_err), 32'd0);
      chk("rst_rdcnt", a_rdcnt, 32'd0);
      chk("rst_wrcnt", a_wrcnt, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_wait", 32'(a_wait), 32'd0);

      // Test 1: write then read, latency 2
      a_cmd(1'b0, 1'b1, 32'h10, 32'hAAAA_1110, 4'hF);
      a_read_check("t1", 32'h10, 32'hAAAA_1110);
      chk("t1_wrcnt", a_wrcnt, 32'd1);
      chk("t1_rdcnt", a_rdcnt, 32'd1);

      // Test 2: byte-enable merge
      a_cmd(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
      a_cmd(1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'b0101);
      a_read_check("t2", 32'h20, 32'hFF34_FF78);

      // Test 3: held read across 4 addresses with one read in flight
      a_cmd(1'b0, 1'b1, 32'h0, 32'd1, 4'hF);
      a_cmd(1'b0, 1'b1, 32'h4, 32'd2, 4'hF);
      a_cmd(1'b0, 1'b1, 32'h8, 32'd3, 4'hF);
      a_cmd(1'b0, 1'b1, 32'hC, 32'd4, 4'hF);
      acc = 0; got_n = 0;
      a_addr = 32'h0; a_read = 1'b1;
      for (int c = 0; c < 40 && got_n < 4; c++) begin
         accepting = !a_wait && a_read;
         tick();
         if (accepting) begin
            acc++;
            chk("t3_wait_after_accept", 32'(a_wait), 32'd1);
            a_addr = 32'(acc * 4);
            if (acc == 4) a_read = 1'b0;
         end
         if (a_rdv && got_n < 4) begin
            got[got_n] = a_rdata;
            got_n++;
         end
      end
      a_read = 1'b0;
      chk("t3_valid_count", 32'(got_n), 32'd4);
      for (int i = 0; i < 4; i++) chk("t3_order", got[i], 32'(i + 1));
      chk("t3_rdcnt", a_rdcnt, 32'd6);
      chk("t3_wrcnt", a_wrcnt, 32'd7);
      chk("t3_err_clear", 32'(a_err), 32'd0);

      // Test 5: out-of-range and read&write together
      a_read_check("t5_oor", 32'h0000_1000, 32'hDEAD_BEEF);
      chk("t5_err_oor", 32'(a_err), 32'd1);
      a_cmd(1'b1, 1'b1, 32'h4, 32'h55, 4'hF);
      for (int i = 0; i < 3; i++) begin
         chk("t5_rw_no_valid", 32'(a_rdv), 32'd0);
         tick();
      end
      chk("t5_rw_rdcnt", a_rdcnt, 32'd7);
      chk("t5_rw_wrcnt", a_wrcnt, 32'd8);
      a_cmd(1'b0, 1'b1, 32'h2000_0000, 32'hBAD0_BAD0, 4'hF);
      a_read_check("t5_alias", 32'h0, 32'd1);
      a_read_check("t5_rw_data", 32'h4, 32'h55);
      a_cmd(1'b0, 1'b1, 32'hFFC, 32'hC0DE_0FFC, 4'hF);
      a_read_check("t5_top", 32'hFFC, 32'hC0DE_0FFC);
      chk("t5_err_sticky", 32'(a_err), 32'd1);
      chk("t5_rdcnt", a_rdcnt, 32'd10);
      chk("t5_wrcnt", a_wrcnt, 32'd10);

      // Test 4: stall generator on instance b
      acc = 0; hist = '0;
      b_addr = 32'h100; b_wdata = 32'hB000_0001; b_be = 4'hF; b_write = 1'b1;
      for (int c = 0; c < 10; c++) begin
         accepting = !b_wait && b_write;
         tick();
         if (accepting) begin
            acc++;
            if (acc == 4) b_write = 1'b0;
            else begin
               b_addr  = 32'h100 + 32'(acc * 4);
               b_wdata = 32'hB000_0001 + 32'(acc);
            end
         end
         hist[c] = b_wait;
      end
      b_write = 1'b0;
      chk("t4_wait_pattern", 32'(hist), 32'(10'b0111001110));
      chk("t4_wrcnt", b_wrcnt, 32'd4);
      b_addr = 32'h10C; b_read = 1'b1;
      chk("t4_rd_ready", 32'(b_wait), 32'd0);
      tick();
      b_read = 1'b0;
      tick();
      chk("t4_rd_valid", 32'(b_rdv), 32'd1);
      chk("t4_rd_data", b_rdata, 32'hB000_0004);

      // Test 6: reset with a read in flight
      a_cmd(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      rst = 1'b1;
      #1;
      chk("t6_wait_in_rst", 32'(a_wait), 32'd1);
      tick();
      rst = 1'b0;
      #1;
      chk("t6_err", 32'(a_err), 32'd0);
      chk("t6_rdcnt", a_rdcnt, 32'd0);
      chk("t6_wrcnt", a_wrcnt, 32'd0);
      chk("t6_rdata", a_rdata, 32'h0);
      chk("t6_wait", 32'(a_wait), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("t6_no_valid", 32'(a_rdv), 32'd0);
         tick();
      end
      a_read_check("t6_keep10", 32'h10, 32'hAAAA_1110);
      a_read_check("t6_keep20", 32'h20, 32'hFF34_FF78);
      chk("t6_rdcnt_after", a_rdcnt, 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
